// File: rtl/lc3_mem_ctrl_pkg.sv
// Shared types and constants for the LC-3 memory/IO controller.
// Region decode lives here so every consumer agrees on the address map.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MCR,
        REG_IO,
        REG_HOLE
    } region_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    localparam logic [15:0] IO_BASE  = 16'hFE00;
    localparam logic [15:0] MCR_ADDR = 16'hFFFE;

    // RAM wins over device space when ADDR_W reaches 16
    function automatic region_e decode(
        input logic [15:0] addr,
        input int unsigned addr_w
    );
        logic [16:0] lim;
        lim = 17'd1 << addr_w;
        if ({1'b0, addr} < lim)
            return REG_RAM;
        else if (addr == MCR_ADDR)
            return REG_MCR;
        else if (addr >= IO_BASE)
            return REG_IO;
        else
            return REG_HOLE;
    endfunction

endpackage

// File: rtl/lc3_mem_ctrl_if.sv
// Core-side memory port of the LC-3: request, write data,
// read data and the single-cycle completion pulse.
interface lc3_mem_ctrl_if;

    logic        memEN;
    logic        memWE;
    logic [15:0] memory_addr;
    logic [15:0] memory_din;
    logic [15:0] memory_dout;
    logic        memRDY;

    modport master (
        output memEN,
        output memWE,
        output memory_addr,
        output memory_din,
        input  memory_dout,
        input  memRDY
    );

    modport slave (
        input  memEN,
        input  memWE,
        input  memory_addr,
        input  memory_din,
        output memory_dout,
        output memRDY
    );

endinterface

// File: rtl/lc3_mem_ctrl_sram.sv
// Single-port synchronous RAM, 16-bit words; read data is the
// old word when read and write hit the same address on one edge.
module lc3_sram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/IO controller: wait-state sequencer, RAM, MCR and
// memory-mapped IO forwarding behind the core memory port.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int          ADDR_W   = 12,
    parameter int          WAIT_CYC = 2,
    parameter logic [15:0] MCR_RST  = 16'h8000
) (
    input  logic               clk,
    input  logic               rst,
    lc3_mem_ctrl_if.slave      bus,
    input  logic [15:0]        MemoryMappedIO_in,
    output logic [15:0]        MemoryMappedIO_out,
    output logic               MemoryMappedIO_load,
    output logic [15:0]        MCR
);

    localparam logic [3:0] WC = 4'(WAIT_CYC);

    state_e      state;
    state_e      nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        latch;
    logic [15:0] addr_q;
    logic [15:0] din_q;
    logic        we_q;
    logic [15:0] dout_q;
    logic [15:0] io_q;
    logic [15:0] mcr_q;
    logic        done;
    region_e     region;
    logic        ram_we;
    logic [15:0] ram_q;
    logic [ADDR_W-1:0] ram_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        latch   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.memEN) begin
                    latch   = 1'b1;
                    cnt_nxt = '0;
                    nxt     = (WC == 4'd0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt_nxt == WC)
                    nxt = DONE;
            end
            DONE: begin
                cnt_nxt = '0;
                nxt     = IDLE;
            end
            default: begin
                cnt_nxt = '0;
                nxt     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            din_q  <= '0;
            we_q   <= 1'b0;
        end else if (latch) begin
            addr_q <= bus.memory_addr;
            din_q  <= bus.memory_din;
            we_q   <= bus.memWE;
        end
    end

    assign done   = (state == DONE);
    assign region = decode(addr_q, ADDR_W);
    assign ram_we = done && we_q && (region == REG_RAM);

    // Read is launched one edge early so the word is ready in DONE
    assign ram_addr = (state == IDLE) ?
                      bus.memory_addr[ADDR_W-1:0] :
                      addr_q[ADDR_W-1:0];

    lc3_sram #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (din_q),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
            io_q   <= '0;
            mcr_q  <= MCR_RST;
        end else if (done) begin
            if (we_q) begin
                if (region == REG_MCR)
                    mcr_q <= din_q;
                if (region == REG_IO)
                    io_q <= din_q;
            end else begin
                unique case (region)
                    REG_RAM:  dout_q <= ram_q;
                    REG_MCR:  dout_q <= mcr_q;
                    REG_IO:   dout_q <= MemoryMappedIO_in;
                    default:  dout_q <= '0;
                endcase
            end
        end
    end

    assign MemoryMappedIO_load = done && we_q &&
                                 (region == REG_IO);
    // Strobe and data are presented together in DONE
    assign MemoryMappedIO_out  = MemoryMappedIO_load ?
                                 din_q : io_q;
    assign MCR             = mcr_q;
    assign bus.memRDY      = done;
    assign bus.memory_dout = dout_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Randomized bench for lc3_mem_ctrl against an address-map model,
// plus a zero-wait-state instance exercising back-to-back requests.
module tb_lc3_mem_ctrl;

    localparam int W  = 2;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lc3_mem_ctrl_if bus ();
    lc3_mem_ctrl_if bus0 ();

    logic [15:0] io_in, io_out, mcr;
    logic        io_ld;
    logic [15:0] io_in0, io_out0, mcr0;
    logic        io_ld0;

    lc3_mem_ctrl #(
        .ADDR_W   (AW),
        .WAIT_CYC (W),
        .MCR_RST  (16'h8000)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .bus                 (bus),
        .MemoryMappedIO_in   (io_in),
        .MemoryMappedIO_out  (io_out),
        .MemoryMappedIO_load (io_ld),
        .MCR                 (mcr)
    );

    lc3_mem_ctrl #(
        .ADDR_W   (AW),
        .WAIT_CYC (0),
        .MCR_RST  (16'h8000)
    ) dut0 (
        .clk                 (clk),
        .rst                 (rst),
        .bus                 (bus0),
        .MemoryMappedIO_in   (io_in0),
        .MemoryMappedIO_out  (io_out0),
        .MemoryMappedIO_load (io_ld0),
        .MCR                 (mcr0)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_ram [4096];
    bit          m_kn  [4096];
    logic [15:0] m_mcr;
    logic [15:0] m_io;
    logic [15:0] m_dout;
    bit          m_dk;

    task automatic chk(string tag, logic [31:0] got,
                       logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    task automatic acc(input bit we, input logic [15:0] a,
                       input logic [15:0] d,
                       input logic [15:0] iv);
        int n;
        bit is_io;
        is_io = (a >= 16'hFE00) && (a != 16'hFFFE);
        bus.memEN       = 1'b1;
        bus.memWE       = we;
        bus.memory_addr = a;
        bus.memory_din  = d;
        io_in           = iv;
        @(posedge clk); #1;
        n = 1;
        while (!bus.memRDY && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, W + 1);
        chk("io_load_done", 32'(io_ld), 32'(we && is_io));
        if (we && is_io)
            chk("io_out_done", io_out, d);
        bus.memEN       = 1'b0;
        bus.memWE       = ~we;
        bus.memory_addr = 16'($urandom);
        bus.memory_din  = 16'($urandom);
        @(posedge clk); #1;
        chk("rdy_pulse", 32'(bus.memRDY), 0);
        chk("io_load_after", 32'(io_ld), 0);
        if (a < 16'd4096) begin
            if (we) begin
                m_ram[a[11:0]] = d;
                m_kn[a[11:0]]  = 1'b1;
            end else begin
                m_dout = m_ram[a[11:0]];
                m_dk   = m_kn[a[11:0]];
            end
        end else if (a == 16'hFFFE) begin
            if (we) m_mcr = d;
            else begin m_dout = m_mcr; m_dk = 1'b1; end
        end else if (is_io) begin
            if (we) m_io = d;
            else begin m_dout = iv; m_dk = 1'b1; end
        end else if (!we) begin
            m_dout = 16'h0000;
            m_dk   = 1'b1;
        end
        if (m_dk)
            chk("dout", bus.memory_dout, m_dout);
        chk("mcr", mcr, m_mcr);
        chk("io_out", io_out, m_io);
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 4))
            0: return 16'($urandom_range(0, 31));
            1: return 16'($urandom_range(0, 4095));
            2: return 16'hFFFE;
            3: return 16'($urandom_range(16'hFE00, 16'hFFFF));
            default: return 16'($urandom_range(4096, 16'hFDFF));
        endcase
    endfunction

    logic [15:0] vals [4];

    initial begin
        bus.memEN = 0; bus.memWE = 0;
        bus.memory_addr = 0; bus.memory_din = 0;
        bus0.memEN = 0; bus0.memWE = 0;
        bus0.memory_addr = 0; bus0.memory_din = 0;
        io_in = 0; io_in0 = 0;
        for (int i = 0; i < 4096; i++) m_kn[i] = 1'b0;
        m_mcr = 16'h8000; m_io = 0; m_dout = 0; m_dk = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_rdy", 32'(bus.memRDY), 0);
        chk("rst_dout", bus.memory_dout, 0);
        chk("rst_mcr", mcr, 16'h8000);
        chk("rst_io_out", io_out, 0);
        chk("rst_io_load", 32'(io_ld), 0);
        #20 rst = 1'b1;
        @(posedge clk); #1;

        acc(1, 16'h0010, 16'h1234, 16'h0);
        acc(0, 16'h0010, 16'h0, 16'h0);
        acc(0, 16'hFFFE, 16'h0, 16'h0);
        acc(1, 16'hFFFE, 16'h7FFF, 16'h0);
        acc(1, 16'hFE06, 16'h0041, 16'h0);
        acc(0, 16'hFE04, 16'h0, 16'h8000);
        acc(1, 16'h0000, 16'h5555, 16'h0);
        acc(1, 16'h3000, 16'hBEEF, 16'h0);
        acc(0, 16'h3000, 16'h0, 16'h0);
        acc(0, 16'h0000, 16'h0, 16'h0);
        acc(1, 16'h0FFF, 16'hA5A5, 16'h0);
        acc(0, 16'h1000, 16'h0, 16'h0);
        acc(0, 16'h0FFF, 16'h0, 16'h0);
        acc(0, 16'hFDFF, 16'h0, 16'h1111);
        acc(1, 16'hFFFF, 16'hC3C3, 16'h0);
        acc(0, 16'hFE00, 16'h0, 16'h2468);

        for (int i = 0; i < 150; i++)
            acc(1'($urandom), pick_addr(),
                16'($urandom), 16'($urandom));

        acc(1, 16'h0020, 16'hAAAA, 16'h0);
        acc(1, 16'hFFFE, 16'h1111, 16'h0);
        bus.memEN = 1; bus.memWE = 1;
        bus.memory_addr = 16'h0020;
        bus.memory_din  = 16'hDEAD;
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        chk("abort_rdy", 32'(bus.memRDY), 0);
        chk("abort_mcr", mcr, 16'h8000);
        bus.memEN = 0;
        m_mcr = 16'h8000; m_io = 0; m_dout = 0; m_dk = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_rdy", 32'(bus.memRDY), 0);
        end
        chk("abort_dout", bus.memory_dout, 0);
        acc(0, 16'h0020, 16'h0, 16'h0);

        for (int i = 0; i < 4; i++) vals[i] = 16'($urandom);
        for (int r = 0; r < 2; r++) begin
            bus0.memEN = 1;
            bus0.memWE = (r == 0);
            bus0.memory_addr = 16'h0040;
            bus0.memory_din  = vals[0];
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                chk("b0_rdy_hi", 32'(bus0.memRDY), 1);
                if (i == 3) begin
                    bus0.memEN = 0;
                end else begin
                    bus0.memory_addr = 16'(16'h0040 + i + 1);
                    bus0.memory_din  = vals[i+1];
                end
                @(posedge clk); #1;
                chk("b0_rdy_lo", 32'(bus0.memRDY), 0);
                if (r == 1)
                    chk("b0_dout", bus0.memory_dout, vals[i]);
            end
        end
        chk("b0_mcr", mcr0, 16'h8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
